// File: rtl/bfn_train_unit.sv
// bfn_train_unit: in-order training stage for the perceptron predictor.
// Predictions queue in a FIFO; the oldest resolves, optionally trains, and the
// saturated row is handed back to the weight table over a valid/ready port.

// One weight lane: step toward the outcome, holding at the [-4,+3] rails.
module bfn_wupd (
  input  logic [2:0] w_i,
  input  logic       up_i,
  output logic [2:0] w_o
);
  // Saturating +/-1 step.
  always_comb begin
    w_o = w_i;
    if (up_i && (w_i != 3'b011))       w_o = w_i + 3'd1;
    else if (!up_i && (w_i != 3'b100)) w_o = w_i - 3'd1;
  end
endmodule

module bfn_train_unit #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 10,
  parameter int THETA = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [IDX_W-1:0] pred_idx,
  input  logic [8:0]       pred_total,
  input  logic [47:0]      pred_conv_w,
  input  logic [143:0]     pred_rs_w,
  input  logic [1:0]       pred_bias,
  input  logic [15:0]      pred_conv_hist,
  input  logic [47:0]      pred_rs_hist,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             res_ready,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [IDX_W-1:0] wb_idx,
  output logic [47:0]      wb_conv_w,
  output logic [143:0]     wb_rs_w,
  output logic [1:0]       wb_bias,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]      cnt_mispred,
  output logic [15:0]      cnt_train
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = 64;  // 16 conv lanes then 48 rs lanes

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [8:0]       total;
    logic [191:0]     w;     // {rs_w, conv_w}
    logic [1:0]       bias;
    logic [63:0]      hist;  // {rs_hist, conv_hist}
  } ent_t;

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  ent_t             mem_q [DEPTH];
  ent_t             head;
  state_t           state_q, state_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      cnt_mispred_q, cnt_mispred_d, cnt_train_q, cnt_train_d;
  logic [IDX_W-1:0] hold_idx_q, hold_idx_d, wb_idx_q, wb_idx_d;
  logic [191:0]     hold_w_q, hold_w_d, wb_w_q, wb_w_d, upd_w;
  logic [63:0]      hold_h_q, hold_h_d;
  logic [1:0]       hold_bias_q, hold_bias_d, wb_bias_q, wb_bias_d, upd_bias;
  logic             hold_taken_q, hold_taken_d, wb_valid_q, wb_valid_d;
  logic             push, pop, mis, train;
  logic [9:0]       tot_x, mag;

  assign pred_ready  = (count_q < CW'(DEPTH));
  assign res_ready   = (state_q == IDLE) && (count_q != '0);
  assign pred_taken  = ~pred_total[8];
  assign occupancy   = count_q;
  assign cnt_mispred = cnt_mispred_q;
  assign cnt_train   = cnt_train_q;
  assign wb_valid    = wb_valid_q;
  assign wb_idx      = wb_idx_q;
  assign wb_conv_w   = wb_w_q[47:0];
  assign wb_rs_w     = wb_w_q[191:48];
  assign wb_bias     = wb_bias_q;

  // Per-lane weight update from the held row.
  for (genvar g = 0; g < NW; g++) begin : g_lane
    bfn_wupd u_wupd (
      .w_i  (hold_w_q[3*g +: 3]),
      .up_i (hold_h_q[g] == hold_taken_q),
      .w_o  (upd_w[3*g +: 3])
    );
  end

  // Bias steps toward the outcome, saturating to [-2,+1].
  always_comb begin
    upd_bias = hold_bias_q;
    if (hold_taken_q && (hold_bias_q != 2'b01))       upd_bias = hold_bias_q + 2'd1;
    else if (!hold_taken_q && (hold_bias_q != 2'b10)) upd_bias = hold_bias_q - 2'd1;
  end

  // FIFO bookkeeping, train decision and resolve/write-back sequencing.
  always_comb begin
    head    = mem_q[head_q];
    push    = pred_valid && pred_ready && !flush;
    pop     = res_valid && res_ready && !flush;
    tot_x   = {head.total[8], head.total};
    mag     = head.total[8] ? (10'd0 - tot_x) : tot_x;
    mis     = (~head.total[8]) != res_taken;
    train   = mis || (mag <= 10'(THETA));

    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    cnt_mispred_d = cnt_mispred_q;
    cnt_train_d   = cnt_train_q;
    hold_idx_d    = hold_idx_q;
    hold_w_d      = hold_w_q;
    hold_h_d      = hold_h_q;
    hold_bias_d   = hold_bias_q;
    hold_taken_d  = hold_taken_q;
    wb_valid_d    = wb_valid_q;
    wb_idx_d      = wb_idx_q;
    wb_w_d        = wb_w_q;
    wb_bias_d     = wb_bias_q;

    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    // Flush empties the queue but leaves an already-resolved update alone.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    case (state_q)
      IDLE: if (pop) begin
        if (mis) cnt_mispred_d = cnt_mispred_q + 16'd1;
        if (train) begin
          cnt_train_d  = cnt_train_q + 16'd1;
          hold_idx_d   = head.idx;
          hold_w_d     = head.w;
          hold_h_d     = head.hist;
          hold_bias_d  = head.bias;
          hold_taken_d = res_taken;
          state_d      = CALC;
        end
      end
      CALC: begin
        wb_valid_d = 1'b1;
        wb_idx_d   = hold_idx_q;
        wb_w_d     = upd_w;
        wb_bias_d  = upd_bias;
        state_d    = WB;
      end
      WB: if (wb_ready) begin
        wb_valid_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry storage; contents are only meaningful between tail and head.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{idx: pred_idx, total: pred_total,
                                 w: {pred_rs_w, pred_conv_w}, bias: pred_bias,
                                 hist: {pred_rs_hist, pred_conv_hist}};
  end

  // Control and output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      cnt_mispred_q <= '0;
      cnt_train_q   <= '0;
      hold_idx_q    <= '0;
      hold_w_q      <= '0;
      hold_h_q      <= '0;
      hold_bias_q   <= '0;
      hold_taken_q  <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_idx_q      <= '0;
      wb_w_q        <= '0;
      wb_bias_q     <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      cnt_mispred_q <= cnt_mispred_d;
      cnt_train_q   <= cnt_train_d;
      hold_idx_q    <= hold_idx_d;
      hold_w_q      <= hold_w_d;
      hold_h_q      <= hold_h_d;
      hold_bias_q   <= hold_bias_d;
      hold_taken_q  <= hold_taken_d;
      wb_valid_q    <= wb_valid_d;
      wb_idx_q      <= wb_idx_d;
      wb_w_q        <= wb_w_d;
      wb_bias_q     <= wb_bias_d;
    end
  end
endmodule

// File: tb/tb_bfn_train_unit.sv
// Bench for bfn_train_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bfn_train_unit;
  localparam int DEPTH = 8;
  localparam int IDX_W = 10;
  localparam int THETA = 20;

  logic clk = 0, rst_n = 0;
  logic pred_valid = 0, pred_ready;
  logic [9:0] pred_idx = 0;
  logic [8:0] pred_total = 0;
  logic [47:0] pred_conv_w = 0;
  logic [143:0] pred_rs_w = 0;
  logic [1:0] pred_bias = 0;
  logic [15:0] pred_conv_hist = 0;
  logic [47:0] pred_rs_hist = 0;
  logic pred_taken;
  logic res_valid = 0, res_taken = 0, res_ready, flush = 0;
  logic wb_valid, wb_ready = 0;
  logic [9:0] wb_idx;
  logic [47:0] wb_conv_w;
  logic [143:0] wb_rs_w;
  logic [1:0] wb_bias;
  logic [3:0] occupancy;
  logic [15:0] cnt_mispred, cnt_train;

  bfn_train_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .THETA(THETA)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_idx(pred_idx),
    .pred_total(pred_total), .pred_conv_w(pred_conv_w), .pred_rs_w(pred_rs_w),
    .pred_bias(pred_bias), .pred_conv_hist(pred_conv_hist), .pred_rs_hist(pred_rs_hist),
    .pred_taken(pred_taken), .res_valid(res_valid), .res_taken(res_taken),
    .res_ready(res_ready), .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_idx(wb_idx), .wb_conv_w(wb_conv_w), .wb_rs_w(wb_rs_w), .wb_bias(wb_bias),
    .occupancy(occupancy), .cnt_mispred(cnt_mispred), .cnt_train(cnt_train)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [9:0] idx; logic [8:0] total; logic [47:0] cw; logic [143:0] rw;
    logic [1:0] b; logic [15:0] ch; logic [47:0] rh;
  } ent_t;

  ent_t q[$];
  bit m_pend = 0;          // a trained row is on its way to / sitting on the wb port
  int m_age = 0;           // 0: one cycle after pop, 1: visible on wb port
  logic [15:0] m_mis = 0, m_trn = 0;
  logic [9:0] e_idx = 0;
  logic [47:0] e_conv = 0;
  logic [143:0] e_rs = 0;
  logic [1:0] e_bias = 0;
  bit pr, rr, m_ev;

  function automatic logic [2:0] sat3(input logic [2:0] w, input bit up);
    int v;
    v = $signed(w) + (up ? 1 : -1);
    if (v > 3) v = 3;
    if (v < -4) v = -4;
    return 3'(v);
  endfunction

  function automatic logic [1:0] sat2(input logic [1:0] w, input bit up);
    int v;
    v = $signed(w) + (up ? 1 : -1);
    if (v > 1) v = 1;
    if (v < -2) v = -2;
    return 2'(v);
  endfunction

  task automatic model_resolve(input ent_t e, input logic tk);
    int t, mag;
    bit mis, trn;
    t = $signed(e.total);
    mis = ((t >= 0) != tk);
    mag = (t < 0) ? -t : t;
    trn = mis || (mag <= THETA);
    if (mis) m_mis++;
    if (trn) begin
      m_trn++;
      m_pend = 1;
      m_age = 0;
      e_idx = e.idx;
      for (int k = 0; k < 16; k++) e_conv[3*k +: 3] = sat3(e.cw[3*k +: 3], e.ch[k] == tk);
      for (int k = 0; k < 48; k++) e_rs[3*k +: 3] = sat3(e.rw[3*k +: 3], e.rh[k] == tk);
      e_bias = sat2(e.b, tk);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete(); m_pend = 0; m_age = 0; m_mis = 0; m_trn = 0;
    end else begin
      pr = (q.size() < DEPTH);
      rr = !m_pend && (q.size() != 0);
      if (m_pend) begin
        if (m_age >= 1 && wb_ready) m_pend = 0;
        else m_age = 1;
      end
      if (flush) q.delete();
      else begin
        if (res_valid && rr) model_resolve(q.pop_front(), res_taken);
        if (pred_valid && pr)
          q.push_back({pred_idx, pred_total, pred_conv_w, pred_rs_w, pred_bias,
                       pred_conv_hist, pred_rs_hist});
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      m_ev = m_pend && (m_age >= 1);
      chk("pred_ready", pred_ready, q.size() < DEPTH);
      chk("res_ready", res_ready, !m_pend && (q.size() != 0));
      chk("occupancy", occupancy, q.size());
      chk("cnt_mispred", cnt_mispred, m_mis);
      chk("cnt_train", cnt_train, m_trn);
      chk("wb_valid", wb_valid, m_ev);
      chk("pred_taken", pred_taken, $signed(pred_total) >= 0);
      if (m_ev) begin
        chk("wb_idx", wb_idx, e_idx);
        chk("wb_conv_w", wb_conv_w, e_conv);
        chk("wb_rs_w", wb_rs_w, e_rs);
        chk("wb_bias", wb_bias, e_bias);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    pred_valid = 0; res_valid = 0; flush = 0;
  endtask

  task automatic set_pred(input int idx, input logic [8:0] tot, input logic [2:0] w,
                          input logic [1:0] b, input logic h);
    pred_valid = 1; pred_idx = 10'(idx); pred_total = tot;
    pred_conv_w = {16{w}}; pred_rs_w = {48{w}}; pred_bias = b;
    pred_conv_hist = {16{h}}; pred_rs_hist = {48{h}};
  endtask

  task automatic push1(input int idx, input logic [8:0] tot, input logic [2:0] w,
                       input logic [1:0] b, input logic h);
    set_pred(idx, tot, w, b, h); tick(); pred_valid = 0;
  endtask

  task automatic resolve(input logic tk);
    int n = 0;
    while (!res_ready && n < 20) begin tick(); n++; end
    if (!res_ready) chk("res_ready_timeout", 1'b0, 1'b1);
    res_valid = 1; res_taken = tk; tick(); res_valid = 0;
  endtask

  task automatic wait_wb();
    int n = 0;
    while (!wb_valid && n < 20) begin tick(); n++; end
    if (!wb_valid) chk("wb_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 0; clr(); wb_ready = 0; tick(); tick(); rst_n = 1; tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed + random scenarios ----------------
  initial begin
    do_reset();
    chk("rst_occupancy", occupancy, 0);
    chk("rst_pred_ready", pred_ready, 1'b1);
    chk("rst_res_ready", res_ready, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_cnt_train", cnt_train, 0);
    chk("rst_cnt_mispred", cnt_mispred, 0);

    // taken, hist all 1, weights already at +3
    push1(1, 9'd5, 3'b011, 2'b01, 1'b1);
    chk("t1_occ", occupancy, 1);
    resolve(1'b1);
    chk("t1_wb_n1", wb_valid, 1'b0);
    tick();
    chk("t1_wb_n2", wb_valid, 1'b1);
    chk("t1_idx", wb_idx, 1);
    chk("t1_conv", wb_conv_w, {16{3'b011}});
    chk("t1_rs", wb_rs_w, {48{3'b011}});
    chk("t1_bias", wb_bias, 2'b01);
    chk("t1_cnt_train", cnt_train, 1);
    chk("t1_cnt_mis", cnt_mispred, 0);
    wb_ready = 1; tick(); wb_ready = 0;
    chk("t1_wb_done", wb_valid, 1'b0);

    // mispredict: total -30, actual taken, weights -4 with hist 0
    push1(2, 9'h1E2, 3'b100, 2'b10, 1'b0);
    resolve(1'b1);
    tick();
    chk("t2_wb", wb_valid, 1'b1);
    chk("t2_conv", wb_conv_w, {16{3'b100}});
    chk("t2_rs", wb_rs_w, {48{3'b100}});
    chk("t2_bias", wb_bias, 2'b11);
    chk("t2_cnt_mis", cnt_mispred, 1);
    chk("t2_cnt_train", cnt_train, 2);
    wb_ready = 1; tick(); wb_ready = 0;

    // confident correct prediction: no training
    push1(3, 9'd40, 3'b000, 2'b00, 1'b1);
    resolve(1'b1);
    chk("t3_occ", occupancy, 0);
    chk("t3_wb_n1", wb_valid, 1'b0);
    tick();
    chk("t3_wb_n2", wb_valid, 1'b0);
    chk("t3_cnt_train", cnt_train, 2);

    // threshold boundaries: +20 trains, +21 does not, -256 with not-taken does not
    push1(4, 9'd20, 3'b000, 2'b00, 1'b1);
    push1(5, 9'd21, 3'b000, 2'b00, 1'b1);
    push1(6, 9'h100, 3'b000, 2'b00, 1'b1);
    wb_ready = 1;
    resolve(1'b1);
    resolve(1'b1);
    resolve(1'b0);
    tick();
    chk("t3b_cnt_train", cnt_train, 3);
    chk("t3b_cnt_mis", cnt_mispred, 1);

    // full FIFO; simultaneous pop does not make room for a push
    do_reset();
    wb_ready = 1;
    for (int i = 0; i < 8; i++) push1(100 + i, 9'd0, 3'b000, 2'b00, 1'b1);
    chk("t4_ready", pred_ready, 1'b0);
    chk("t4_occ8", occupancy, 8);
    set_pred(200, 9'd0, 3'b000, 2'b00, 1'b1);
    res_valid = 1; res_taken = 1; tick(); clr();
    chk("t4_occ7", occupancy, 7);
    wait_wb();
    chk("t4_idx0", wb_idx, 100);
    for (int i = 1; i < 8; i++) begin
      resolve(1'b1);
      wait_wb();
      chk("t4_idx", wb_idx, 10'(100 + i));
    end
    tick();
    chk("t4_occ0", occupancy, 0);
    chk("t4_cnt_train", cnt_train, 8);

    // backpressure: write-back held for five cycles
    wb_ready = 0;
    push1(300, 9'd3, 3'b001, 2'b00, 1'b1);
    push1(301, 9'd3, 3'b001, 2'b00, 1'b1);
    resolve(1'b1);
    wait_wb();
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid", wb_valid, 1'b1);
      chk("t5_res_ready", res_ready, 1'b0);
      chk("t5_idx", wb_idx, 300);
      chk("t5_conv", wb_conv_w, {16{3'b010}});
      chk("t5_bias", wb_bias, 2'b01);
      tick();
    end
    wb_ready = 1; tick(); wb_ready = 0;
    chk("t5_done", wb_valid, 1'b0);
    chk("t5_res_ready1", res_ready, 1'b1);

    // flush with three queued while in write-back
    resolve(1'b1);
    wait_wb();
    for (int i = 0; i < 3; i++) push1(400 + i, 9'd0, 3'b000, 2'b00, 1'b1);
    chk("t6_occ3", occupancy, 3);
    flush = 1; tick(); flush = 0;
    chk("t6_occ0", occupancy, 0);
    chk("t6_wb", wb_valid, 1'b1);
    chk("t6_idx", wb_idx, 301);
    wb_ready = 1; tick(); wb_ready = 0;
    chk("t6_done", wb_valid, 1'b0);

    // asynchronous reset while a trained row is being computed
    push1(500, 9'd0, 3'b000, 2'b00, 1'b1);
    resolve(1'b1);
    #2 rst_n = 0;
    #1;
    chk("t7_wb", wb_valid, 1'b0);
    chk("t7_occ", occupancy, 0);
    chk("t7_res_ready", res_ready, 1'b0);
    chk("t7_cnt_train", cnt_train, 0);
    chk("t7_idx", wb_idx, 0);
    tick(); rst_n = 1;
    repeat (3) tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pred_valid = ($urandom_range(0, 2) != 0);
      pred_idx = 10'($urandom());
      pred_total = ($urandom_range(0, 3) == 0) ? 9'($urandom()) : 9'($urandom_range(0, 60) - 30);
      pred_conv_w = 48'({$urandom(), $urandom()});
      pred_rs_w = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      pred_bias = 2'($urandom());
      pred_conv_hist = 16'($urandom());
      pred_rs_hist = 48'({$urandom(), $urandom()});
      res_valid = $urandom_range(0, 1);
      res_taken = $urandom_range(0, 1);
      flush = ($urandom_range(0, 39) == 0);
      wb_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    clr(); wb_ready = 1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
